// File: rtl/cram_loader_pkg.sv
// Shared types for the CRAM configuration loader.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cram_loader_pkg;

  // Loader control states. FETCH is the one-cycle-minimum bubble where a word is
  // accepted. SHIFT streams that word onto the chain.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/cram_piso.sv
// Parallel-in serial-out shift register, MSB first, left shift.
// Latency: a loaded word's MSB is visible on msb the cycle after load.
// Backpressure: none; load takes priority over shift, and the register holds when both are low.
//
// Ports:
//   clk, nrst : clock and async active-low reset (clears the register)
//   load, din : parallel load of a full word
//   shift     : shift left by one bit, zero fill
//   msb       : current top bit (serial output)
module cram_piso #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] din,
  output logic                  msb
);

  logic [WORD_WIDTH-1:0] shreg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= shreg << 1;
    end
  end

  assign msb = shreg[WORD_WIDTH-1];

endmodule

// File: rtl/cram_config_loader.sv
// Serialises config words MSB-first onto the CRAM chain. Fabric stays disabled until exactly CHAIN_LENGTH bits are shifted.
// Latency: each word costs one FETCH cycle plus min(WORD_WIDTH, bits_left) SHIFT cycles. All outputs are registered.
// Backpressure: word_ready is high only in FETCH. The chain holds (cfg_en=0) for as long as no word is offered.
//
// Ports:
//   clk, nrst             : clock (also the chain clock) and async active-low reset
//   start, abort          : begin a load / cancel a load in progress
//   word_data/valid/ready : config word stream
//   cfg_data, cfg_en      : serial data and shift enable for the chain
//   fabric_en             : enables the cells' logic once configuration is complete
//   busy, done, bits_left : load status and remaining chain bits
module cram_config_loader
  import cram_loader_pkg::*;
#(
  parameter int  WORD_WIDTH   = 32,
  parameter int  CHAIN_LENGTH = 1024,
  localparam int CNT_W        = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cfg_data,
  output logic                  cfg_en,
  output logic                  fabric_en,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bits_left
);

  localparam int NS_W = $clog2(WORD_WIDTH + 1);

  ldr_state_t       state_q, state_nxt;
  logic [CNT_W-1:0] bits_left_q, bits_left_nxt;
  logic [NS_W-1:0]  nshift_q, nshift_nxt;
  logic             piso_load, piso_shift;
  logic             word_ready_q, cfg_en_q, busy_q, done_q, fabric_en_q;

  always_comb begin
    state_nxt     = state_q;
    bits_left_nxt = bits_left_q;
    nshift_nxt    = nshift_q;
    piso_load     = 1'b0;
    piso_shift    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // Abort is meaningless here, so start always wins.
        if (start) begin
          state_nxt     = FETCH;
          bits_left_nxt = CNT_W'(CHAIN_LENGTH);
        end
      end
      FETCH: begin
        if (abort) begin
          // A word offered in this same cycle is dropped.
          state_nxt     = IDLE;
          bits_left_nxt = '0;
        end else if (word_valid && word_ready_q) begin
          piso_load = 1'b1;
          state_nxt = SHIFT;
          // On a partial final word only the top bits go out. Its low bits stay in the register.
          if (32'(bits_left_q) < 32'(WORD_WIDTH)) begin
            nshift_nxt = NS_W'(bits_left_q);
          end else begin
            nshift_nxt = NS_W'(WORD_WIDTH);
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt     = IDLE;
          bits_left_nxt = '0;
        end else begin
          piso_shift    = 1'b1;
          bits_left_nxt = bits_left_q - CNT_W'(1);
          nshift_nxt    = nshift_q - NS_W'(1);
          if (nshift_q == NS_W'(1)) begin
            state_nxt = (bits_left_q == CNT_W'(1)) ? DONE : FETCH;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state and registered with it. This keeps them
  // glitch-free and aligned with the state they describe.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      bits_left_q  <= '0;
      nshift_q     <= '0;
      word_ready_q <= 1'b0;
      cfg_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fabric_en_q  <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      bits_left_q  <= bits_left_nxt;
      nshift_q     <= nshift_nxt;
      word_ready_q <= (state_nxt == FETCH);
      cfg_en_q     <= (state_nxt == SHIFT);
      busy_q       <= (state_nxt == FETCH) || (state_nxt == SHIFT);
      done_q       <= (state_nxt == DONE);
      fabric_en_q  <= (state_nxt == DONE);
    end
  end

  cram_piso #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_piso (
    .clk  (clk),
    .nrst (nrst),
    .load (piso_load),
    .shift(piso_shift),
    .din  (word_data),
    .msb  (cfg_data)
  );

  assign word_ready = word_ready_q;
  assign cfg_en     = cfg_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fabric_en  = fabric_en_q;
  assign bits_left  = bits_left_q;

endmodule

// File: tb/tb_cram_config_loader.sv
// Self-checking bench for cram_config_loader with WORD_WIDTH=8 and CHAIN_LENGTH=20.
// Latency: n/a (bench).
// Backpressure: the word feeder honours word_ready and inserts per-word valid gaps.
module tb_cram_config_loader;

  localparam int WW    = 8;
  localparam int CL    = 20;
  localparam int CNT_W = $clog2(CL + 1);

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WW-1:0]    word_data = '0;
  logic             word_valid = 1'b0;
  logic             word_ready, cfg_data, cfg_en, fabric_en, busy, done;
  logic [CNT_W-1:0] bits_left;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cram_config_loader #(
    .WORD_WIDTH  (WW),
    .CHAIN_LENGTH(CL)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .abort     (abort),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .cfg_data  (cfg_data),
    .cfg_en    (cfg_en),
    .fabric_en (fabric_en),
    .busy      (busy),
    .done      (done),
    .bits_left (bits_left)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one load of three 8-bit words (words[23:16] goes first).
  // gaps holds the extra FETCH cycles for each word, 4 bits per word, first word in the top nibble.
  // abort_at / restart_at fire during the cfg_en cycle that carries that bit number (1-based). -1 disables them.
  task automatic run_load(input string tag, input logic [23:0] words, input logic [11:0] gaps,
                          input int abort_at, input int restart_at,
                          input int exp_cycles, input logic [CL-1:0] exp_bits);
    int          wi = 0;
    int          cyc = 0;
    int          nbits = 0;
    int          hs = 0;
    int          gapcnt;
    int          gv[3];
    int          bl = 0;
    bit          will_hs, do_abort, do_restart;
    bit          fab_bad = 0;
    logic [CL-1:0] got = '0;
    gv[0] = int'(gaps[11:8]);
    gv[1] = int'(gaps[7:4]);
    gv[2] = int'(gaps[3:0]);
    gapcnt = gv[0];
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_start_busy"},      32'(busy),      32'd1);
    chk({tag, "_start_done"},      32'(done),      32'd0);
    chk({tag, "_start_fabric_en"}, 32'(fabric_en), 32'd0);
    chk({tag, "_start_bits_left"}, 32'(bits_left), 32'(CL));
    chk({tag, "_start_ready"},     32'(word_ready), 32'd1);
    while (!done && cyc < 400) begin
      if (cfg_en) begin
        if (nbits < CL) got[CL-1-nbits] = cfg_data;
        nbits++;
      end
      if (fabric_en && busy) fab_bad = 1'b1;
      // Feeder: the gap counts down only while the loader is actually waiting for a word.
      if (wi < 3 && gapcnt > 0) begin
        word_valid = 1'b0;
        if (word_ready) gapcnt--;
      end else if (wi < 3) begin
        word_valid = 1'b1;
        word_data  = words[23-8*wi -: 8];
      end else begin
        word_valid = 1'b0;
      end
      will_hs    = word_valid && word_ready;
      do_abort   = cfg_en && (nbits == abort_at);
      do_restart = cfg_en && (nbits == restart_at);
      abort      = do_abort;
      if (do_restart) begin
        start = 1'b1;
        bl    = int'(bits_left);
      end
      step();
      cyc++;
      abort = 1'b0;
      start = 1'b0;
      if (will_hs && !do_abort) begin
        hs++;
        wi++;
        if (wi < 3) gapcnt = gv[wi];
      end
      if (do_restart) begin
        chk({tag, "_restart_bits_left"}, 32'(bits_left), 32'(bl - 1));
        chk({tag, "_restart_busy"},      32'(busy),      32'd1);
      end
      if (do_abort) begin
        word_valid = 1'b0;
        chk({tag, "_abort_busy"},      32'(busy),       32'd0);
        chk({tag, "_abort_done"},      32'(done),       32'd0);
        chk({tag, "_abort_fabric_en"}, 32'(fabric_en),  32'd0);
        chk({tag, "_abort_cfg_en"},    32'(cfg_en),     32'd0);
        chk({tag, "_abort_bits_left"}, 32'(bits_left),  32'd0);
        chk({tag, "_abort_ready"},     32'(word_ready), 32'd0);
        return;
      end
    end
    word_valid = 1'b0;
    chk({tag, "_timeout"},     32'(cyc >= 400), 32'd0);
    chk({tag, "_done_cycle"},  32'(cyc),        32'(exp_cycles));
    chk({tag, "_bit_count"},   32'(nbits),      32'(CL));
    chk({tag, "_bit_stream"},  32'(got),        32'(exp_bits));
    chk({tag, "_handshakes"},  32'(hs),         32'd3);
    chk({tag, "_fabric_en"},   32'(fabric_en),  32'd1);
    chk({tag, "_end_busy"},    32'(busy),       32'd0);
    chk({tag, "_end_bits"},    32'(bits_left),  32'd0);
    chk({tag, "_end_cfg_en"},  32'(cfg_en),     32'd0);
    chk({tag, "_fab_in_load"}, 32'(fab_bad),    32'd0);
  endtask

  typedef struct {
    logic [23:0]   words;
    logic [11:0]   gaps;
    logic [CL-1:0] exp_bits;
    int            exp_cycles;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [23:0]   rw;
    logic [11:0]   rg;
    logic [CL-1:0] rexp;
    int            rcyc;
    int            cnt;

    tbl[0] = '{24'hA53CF0, 12'h000, 20'hA53CF, 23};
    tbl[1] = '{24'hFF00C3, 12'h555, 20'hFF00C, 38};
    tbl[2] = '{24'h01807E, 12'h222, 20'h01807, 29};
    tbl[3] = '{24'h123456, 12'h103, 20'h12345, 27};

    // All outputs must be low while reset is held.
    #12;
    chk("rst_ready",     32'(word_ready), 32'd0);
    chk("rst_cfg_data",  32'(cfg_data),   32'd0);
    chk("rst_cfg_en",    32'(cfg_en),     32'd0);
    chk("rst_fabric_en", 32'(fabric_en),  32'd0);
    chk("rst_busy",      32'(busy),       32'd0);
    chk("rst_done",      32'(done),       32'd0);
    chk("rst_bits_left", 32'(bits_left),  32'd0);
    @(negedge clk);
    nrst = 1'b1;
    step();

    // Loads after the first one start from DONE, so each start must drop done and fabric_en.
    for (int i = 0; i < 4; i++) begin
      run_load($sformatf("vec%0d", i), tbl[i].words, tbl[i].gaps, -1, -1,
               tbl[i].exp_cycles, tbl[i].exp_bits);
    end

    // An abort issued in DONE has no effect.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("done_abort_done",      32'(done),      32'd1);
    chk("done_abort_fabric_en", 32'(fabric_en), 32'd1);
    chk("done_abort_busy",      32'(busy),      32'd0);

    // Abort issued after 11 bits have been shifted.
    run_load("abort", 24'hA53CF0, 12'h000, 11, -1, 0, '0);

    // A start pulse during SHIFT is ignored, and the load completes normally.
    run_load("restart", 24'hA53CF0, 12'h000, -1, 5, 23, 20'hA53CF);

    // Reset asserted mid-SHIFT clears the outputs asynchronously.
    start = 1'b1;
    step();
    start = 1'b0;
    word_valid = 1'b1;
    word_data  = 8'hA5;
    cnt = 0;
    for (int c = 0; c < 50 && cnt < 3; c++) begin
      if (cfg_en) cnt++;
      if (cnt < 3) step();
    end
    chk("midrst_reached_shift", 32'(cnt), 32'd3);
    #2;
    nrst = 1'b0;
    #1;
    word_valid = 1'b0;
    chk("midrst_ready",     32'(word_ready), 32'd0);
    chk("midrst_cfg_data",  32'(cfg_data),   32'd0);
    chk("midrst_cfg_en",    32'(cfg_en),     32'd0);
    chk("midrst_fabric_en", 32'(fabric_en),  32'd0);
    chk("midrst_busy",      32'(busy),       32'd0);
    chk("midrst_done",      32'(done),       32'd0);
    chk("midrst_bits_left", 32'(bits_left),  32'd0);
    @(negedge clk);
    nrst = 1'b1;
    step();
    run_load("post_rst", 24'hA53CF0, 12'h000, -1, -1, 23, 20'hA53CF);

    // Random loads. The chain receives the top CL bits of the concatenated words, MSB first.
    // Each word costs one fetch bubble plus its gap, and the chain costs one cycle per bit.
    for (int r = 0; r < 6; r++) begin
      rw = 24'($urandom);
      rg = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      for (int b = 0; b < CL; b++) rexp[CL-1-b] = rw[23-b];
      rcyc = 3 + int'(rg[11:8]) + int'(rg[7:4]) + int'(rg[3:0]) + CL;
      run_load($sformatf("rand%0d", r), rw, rg, -1, -1, rcyc, rexp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
